// File: rtl/signed_accumulator_if.sv
// signed_accumulator_if
//   Groups the stream input, clear strobe and result handshake of
//   signed_accumulator into one bundle.
//   Parameter: WIDTH  - operand / accumulator width in bits.
//   Signals:
//     in_valid  - upstream word present on in_data
//     in_ready  - accumulator accepts in_data this cycle
//     in_data   - signed operand
//     clear     - synchronous abort of the current batch
//     out_valid - batch result available
//     out_ready - downstream accepts the result
//     acc_out   - signed running / final batch sum
//     ovf       - sticky signed-overflow flag for the current batch
//   Modports: master (producer/consumer side), slave (accumulator side).
interface signed_accumulator_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] acc_out;
    logic             ovf;

    modport master (
        output in_valid, in_data, clear, out_ready,
        input  in_ready, out_valid, acc_out, ovf
    );

    modport slave (
        input  in_valid, in_data, clear, out_ready,
        output in_ready, out_valid, acc_out, ovf
    );
endinterface

// File: rtl/signed_accumulator.sv
// signed_accumulator
//   Sums N_TERMS signed operands per batch and presents the result with a
//   valid/ready handshake. A sticky flag reports signed overflow within the
//   batch.
//   Parameters:
//     WIDTH   - operand / accumulator width (two's complement)
//     N_TERMS - operands per batch, 1..255
//   Ports:
//     clk - clock, rising edge
//     rst - asynchronous, active-high reset
//     bus - signed_accumulator_if.slave (in_valid/in_ready/in_data, clear,
//           out_valid/out_ready, acc_out, ovf)
//   Build option:
//     SIGNED_ACCUMULATOR_SAT_EN - when defined, an overflowing addition loads
//     the signed max/min instead of wrapping modulo 2^WIDTH. ovf behaves the
//     same either way.
module signed_accumulator #(
    parameter int WIDTH   = 32,
    parameter int N_TERMS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    signed_accumulator_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] LP_N_TERMS = 8'(N_TERMS);
`ifdef SIGNED_ACCUMULATOR_SAT_EN
    localparam logic [WIDTH-1:0] LP_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] LP_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [7:0]       r_cnt;
    logic             r_ovf;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [7:0]       w_cnt_nxt;
    logic             w_ovf_nxt;

    logic             w_xfer;
    logic [WIDTH-1:0] w_sum;
    logic             w_add_ovf;
    logic [WIDTH-1:0] w_acc_add;
    logic [7:0]       w_cnt_inc;

    // Datapath. acc is held at zero in IDLE, so the first word of a batch
    // goes through the same adder (0 + x) and can never flag overflow.
    always_comb begin
        w_xfer    = bus.in_valid && (r_state != DONE);
        w_sum     = r_acc + bus.in_data;
        w_add_ovf = (r_acc[WIDTH-1] == bus.in_data[WIDTH-1]) &&
                    (w_sum[WIDTH-1] != r_acc[WIDTH-1]);
        w_cnt_inc = r_cnt + 8'd1;
`ifdef SIGNED_ACCUMULATOR_SAT_EN
        // Both addends share a sign on overflow; that sign picks the rail.
        if (w_add_ovf)
            w_acc_add = r_acc[WIDTH-1] ? LP_MIN : LP_MAX;
        else
            w_acc_add = w_sum;
`else
        w_acc_add = w_sum;
`endif
    end

    // Next-state and outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;

        bus.in_ready  = (r_state != DONE);
        bus.out_valid = (r_state == DONE);
        bus.acc_out   = r_acc;
        bus.ovf       = r_ovf;

        if (bus.clear) begin
            // clear outranks any coincident transfer or result handshake
            w_state_nxt = IDLE;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_ovf_nxt   = 1'b0;
        end else begin
            case (r_state)
                IDLE, ACCUM: begin
                    if (w_xfer) begin
                        w_acc_nxt   = w_acc_add;
                        w_cnt_nxt   = w_cnt_inc;
                        w_ovf_nxt   = r_ovf | w_add_ovf;
                        w_state_nxt = (w_cnt_inc == LP_N_TERMS) ? DONE : ACCUM;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        w_state_nxt = IDLE;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_ovf_nxt   = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

endmodule

// File: tb/tb_signed_accumulator.sv
// tb_signed_accumulator
//   Directed bench for signed_accumulator (WIDTH=32, N_TERMS=4) plus a second
//   instance with N_TERMS=1. Expected values are hand-computed; the
//   overflow-result expectations follow SIGNED_ACCUMULATOR_SAT_EN.
module tb_signed_accumulator;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    signed_accumulator_if #(.WIDTH(32)) u_if  ();
    signed_accumulator_if #(.WIDTH(32)) u_if1 ();

    signed_accumulator #(.WIDTH(32), .N_TERMS(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    signed_accumulator #(.WIDTH(32), .N_TERMS(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (u_if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SIGNED_ACCUMULATOR_SAT_EN
    localparam logic [31:0] EXP_POS_OVF  = 32'h7FFF_FFFF;
    localparam logic [31:0] EXP_NEG_OVF  = 32'h8000_0000;
    localparam logic [31:0] EXP_SAT_CONT = 32'h7FFF_FFFE;
`else
    localparam logic [31:0] EXP_POS_OVF  = 32'h8000_0000;
    localparam logic [31:0] EXP_NEG_OVF  = 32'h7FFF_FFFF;
    localparam logic [31:0] EXP_SAT_CONT = 32'h7FFF_FFFF;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One transfer on the 4-term instance; returns at posedge + 1.
    task automatic send(input logic [31:0] d);
        u_if.in_valid = 1'b1;
        u_if.in_data  = d;
        @(posedge clk);
        #1;
        u_if.in_valid = 1'b0;
        u_if.in_data  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ov"},  32'(u_if.out_valid), 32'd0);
        check({tag, "_rdy"}, 32'(u_if.in_ready),  32'd1);
        check({tag, "_acc"}, u_if.acc_out,        32'd0);
        check({tag, "_ovf"}, 32'(u_if.ovf),       32'd0);
    endtask

    task automatic check_done(input string tag, input logic [31:0] acc, input logic ovf);
        check({tag, "_ov"},  32'(u_if.out_valid), 32'd1);
        check({tag, "_rdy"}, 32'(u_if.in_ready),  32'd0);
        check({tag, "_acc"}, u_if.acc_out,        acc);
        check({tag, "_ovf"}, 32'(u_if.ovf),       32'(ovf));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        u_if.in_valid  = 1'b0;
        u_if.in_data   = '0;
        u_if.clear     = 1'b0;
        u_if.out_ready = 1'b1;
        u_if1.in_valid  = 1'b0;
        u_if1.in_data   = '0;
        u_if1.clear     = 1'b0;
        u_if1.out_ready = 1'b1;

        // Reset state
        #12;
        check_idle("rst");
        check("rst1_rdy", 32'(u_if1.in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic batch with running sum and one-cycle out_valid
        send(32'd1010);
        check("b1_run1", u_if.acc_out, 32'd1010);
        check("b1_ov1", 32'(u_if.out_valid), 32'd0);
        send(32'd1000);
        check("b1_run2", u_if.acc_out, 32'd2010);
        send(-32'sd263784);
        check("b1_run3", u_if.acc_out, 32'hFFFC_0172);
        check("b1_ov3", 32'(u_if.out_valid), 32'd0);
        send(32'd27383);
        check_done("b1", 32'hFFFC_6C69, 1'b0);
        tick();
        check_idle("b1_after");

        // Positive overflow, stall in DONE with in_valid high
        u_if.out_ready = 1'b0;
        send(32'h7FFF_FFFF);
        send(32'd1);
        check("b2_ovf_early", 32'(u_if.ovf), 32'd1);
        send(32'd0);
        send(32'd0);
        check_done("b2", EXP_POS_OVF, 1'b1);
        u_if.in_valid = 1'b1;
        u_if.in_data  = 32'd5;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_done("b2_hold", EXP_POS_OVF, 1'b1);
        end
        u_if.in_valid  = 1'b0;
        u_if.out_ready = 1'b1;
        tick();
        check_idle("b2_after");

        // Negative overflow
        send(32'h8000_0000);
        send(32'hFFFF_FFFF);
        send(32'd0);
        send(32'd0);
        check_done("b3", EXP_NEG_OVF, 1'b1);
        tick();
        check_idle("b3_after");

        // Continuing after an overflow: 7FFFFFFF, 1, -1, 0
        send(32'h7FFF_FFFF);
        send(32'd1);
        send(32'hFFFF_FFFF);
        send(32'd0);
        check_done("b4", EXP_SAT_CONT, 1'b1);
        tick();

        // clear after two words, coinciding with a transfer
        send(32'd5);
        send(32'd7);
        check("b5_run", u_if.acc_out, 32'd12);
        u_if.clear = 1'b1;
        send(32'd99);
        u_if.clear = 1'b0;
        check_idle("b5_clr");
        send(32'd10);
        send(32'd20);
        send(32'd30);
        send(32'd40);
        check_done("b5", 32'd100, 1'b0);
        tick();

        // clear while stalled in DONE outranks the handshake decision
        u_if.out_ready = 1'b0;
        send(32'd1);
        send(32'd1);
        send(32'd1);
        send(32'd1);
        check_done("b6", 32'd4, 1'b0);
        u_if.clear = 1'b1;
        tick();
        u_if.clear = 1'b0;
        u_if.out_ready = 1'b1;
        check_idle("b6_clr");

        // Asynchronous reset between edges mid-batch
        send(32'd100);
        send(32'd200);
        #2;
        rst = 1'b1;
        #1;
        check_idle("b7_rst");
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(32'd1);
        send(32'd2);
        send(32'd3);
        send(32'd4);
        check_done("b7", 32'd10, 1'b0);
        tick();
        check_idle("b7_after");

        // N_TERMS=1 instance: one word completes a batch
        u_if1.in_valid = 1'b1;
        u_if1.in_data  = 32'hFFFF_FFFB;
        tick();
        u_if1.in_valid = 1'b0;
        check("n1_ov",  32'(u_if1.out_valid), 32'd1);
        check("n1_rdy", 32'(u_if1.in_ready),  32'd0);
        check("n1_acc", u_if1.acc_out,        32'hFFFF_FFFB);
        tick();
        check("n1_ov_after",  32'(u_if1.out_valid), 32'd0);
        check("n1_acc_after", u_if1.acc_out,        32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
